// File: rtl/axi_lite_ram_responder.sv
// AXI-lite word-organised RAM target with independent write/read FSMs and programmable response latency.
// Optional feature macro: AXI_RAM_ERR_RESP_EN (SLVERR on out-of-range/misaligned accesses).
module axi_lite_ram_responder #(
  parameter int unsigned                 AXI_ADDR_WIDTH = 64,
  parameter int unsigned                 AXI_DATA_WIDTH = 64,
  parameter logic [AXI_ADDR_WIDTH-1:0]   MEM_BEGIN      = '0,
  parameter int unsigned                 MEM_DEPTH      = 512,
  parameter int unsigned                 WR_LATENCY     = 1,
  parameter int unsigned                 RD_LATENCY     = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [AXI_ADDR_WIDTH-1:0]     awaddr,
  input  logic [2:0]                    awport,
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [AXI_DATA_WIDTH-1:0]     wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   wstrb,
  input  logic                          wvalid,
  output logic                          wready,
  output logic [1:0]                    bresp,
  output logic                          bvalid,
  input  logic                          bready,
  input  logic [AXI_ADDR_WIDTH-1:0]     araddr,
  input  logic [2:0]                    arport,
  input  logic                          arvalid,
  output logic                          arready,
  output logic [AXI_DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                    rresp,
  output logic                          rvalid,
  input  logic                          rready
);

  localparam int unsigned DB   = AXI_DATA_WIDTH / 8;
  localparam int unsigned OFFW = $clog2(DB);
  localparam int unsigned IDXW = $clog2(MEM_DEPTH);
  localparam logic [AXI_ADDR_WIDTH:0] MEM_END =
    {1'b0, MEM_BEGIN} + (AXI_ADDR_WIDTH+1)'(MEM_DEPTH * DB);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_WAIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_WAIT, R_DATA} r_state_t;

  w_state_t wstate;
  r_state_t rstate;
  logic [3:0] wcnt, rcnt;
  logic [AXI_ADDR_WIDTH-1:0] raddr_q;
  logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= {1'b0, MEM_BEGIN}) && ({1'b0, a} < MEM_END);
  endfunction

  function automatic logic [IDXW-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] a);
    logic [AXI_ADDR_WIDTH-1:0] off;
    off = (a - MEM_BEGIN) >> OFFW;
    return IDXW'(off);
  endfunction

  // With zero read latency the sample edge is the R_ACK exit, so the live araddr is used.
  logic [AXI_ADDR_WIDTH-1:0] rd_addr;
  assign rd_addr = (rstate == R_ACK) ? araddr : raddr_q;

  logic       w_drop, r_drop;
  logic [1:0] w_resp_nxt, r_resp_nxt;

`ifdef AXI_RAM_ERR_RESP_EN
  function automatic logic misaligned(input logic [AXI_ADDR_WIDTH-1:0] a);
    return (a & AXI_ADDR_WIDTH'(DB - 1)) != '0;
  endfunction

  assign w_drop     = !in_range(awaddr) || misaligned(awaddr);
  assign r_drop     = !in_range(rd_addr) || misaligned(rd_addr);
  assign w_resp_nxt = w_drop ? SLVERR : OKAY;
  assign r_resp_nxt = r_drop ? SLVERR : OKAY;
`else
  assign w_drop     = !in_range(awaddr);
  assign r_drop     = !in_range(rd_addr);
  assign w_resp_nxt = OKAY;
  assign r_resp_nxt = OKAY;
`endif

  logic [AXI_DATA_WIDTH-1:0] rd_word;
  assign rd_word = r_drop ? '0 : mem[word_idx(rd_addr)];

  logic unused;
  assign unused = ^{awport, arport};

  always_ff @(posedge clk) begin
    if (wstate == W_ACK && !w_drop) begin
      for (int unsigned i = 0; i < DB; i++) begin
        if (wstrb[i]) mem[word_idx(awaddr)][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wstate  <= W_IDLE;
      wcnt    <= '0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
    end else begin
      case (wstate)
        W_IDLE: if (awvalid && wvalid) begin
          wstate  <= W_ACK;
          awready <= 1'b1;
          wready  <= 1'b1;
        end
        W_ACK: begin
          awready <= 1'b0;
          wready  <= 1'b0;
          bresp   <= w_resp_nxt;
          if (WR_LATENCY == 0) begin
            wstate <= W_RESP;
            bvalid <= 1'b1;
          end else begin
            wcnt   <= 4'(WR_LATENCY);
            wstate <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (wcnt != '0) wcnt <= wcnt - 4'd1;
          if (wcnt <= 4'd1) begin
            wstate <= W_RESP;
            bvalid <= 1'b1;
          end
        end
        W_RESP: if (bready) begin
          bvalid <= 1'b0;
          wstate <= W_IDLE;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rstate  <= R_IDLE;
      rcnt    <= '0;
      raddr_q <= '0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= OKAY;
    end else begin
      case (rstate)
        R_IDLE: if (arvalid) begin
          rstate  <= R_ACK;
          arready <= 1'b1;
        end
        R_ACK: begin
          arready <= 1'b0;
          raddr_q <= araddr;
          if (RD_LATENCY == 0) begin
            rstate <= R_DATA;
            rvalid <= 1'b1;
            rdata  <= rd_word;
            rresp  <= r_resp_nxt;
          end else begin
            rcnt   <= 4'(RD_LATENCY);
            rstate <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (rcnt != '0) rcnt <= rcnt - 4'd1;
          if (rcnt <= 4'd1) begin
            rstate <= R_DATA;
            rvalid <= 1'b1;
            rdata  <= rd_word;
            rresp  <= r_resp_nxt;
          end
        end
        R_DATA: if (rready) begin
          rvalid <= 1'b0;
          rstate <= R_IDLE;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule
